// File: rtl/pipeline_pkg.sv
// Shared widths, types and the MEM/WB bundle layout for the 24-bit pipeline.
package pipeline_pkg;

    localparam int DATA_W    = 24;
    localparam int REG_W     = 4;
    localparam int MEM_DEPTH = 256;
    localparam int ADDR_W    = $clog2(MEM_DEPTH);

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [REG_W-1:0]  reg_idx_t;

    typedef struct packed {
        logic     regWe;
        data_t    data;
        reg_idx_t regIdx;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_RESET = '{regWe: 1'b0, data: '0, regIdx: '0};

endpackage

// File: rtl/memory_stage_data_memory.sv
// Data memory: synchronous write, asynchronous read.
// A same-edge write and read of one address returns the old word.
module data_memory #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8,
    parameter int DATA_W = 24
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wrData,
    output logic [DATA_W-1:0] rdData
);

    // Contents are deliberately not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wrData;
        end
    end

    assign rdData = mem[addr];

endmodule

// File: rtl/memory_stage.sv
// MEM stage: data-memory access, write-back select, and the MEM/WB register.
module memory_stage
    import pipeline_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        memWe,
    input  logic        writeRegFromAlu,
    input  logic        regWe,
    input  data_t       dataToWrite,
    input  data_t       result,
    input  reg_idx_t    regToWrite,
    output logic        regWeOut,
    output data_t       dataToWriteOut,
    output reg_idx_t    regToWriteOut
);

    logic [ADDR_W-1:0] memAddr;
    data_t             memRdData;
    data_t             wbData;
    logic              memWriteEn;
    mem_wb_t           memWbQ;

    // Upper result bits do not reach the memory, so addresses wrap.
    assign memAddr    = result[ADDR_W-1:0];
    assign memWriteEn = memWe && !reset;

    data_memory #(
        .DEPTH  (MEM_DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dataMem (
        .clk    (clk),
        .we     (memWriteEn),
        .addr   (memAddr),
        .wrData (dataToWrite),
        .rdData (memRdData)
    );

    assign wbData = writeRegFromAlu ? result : memRdData;

    always_ff @(posedge clk) begin
        if (reset) begin
            memWbQ <= MEM_WB_RESET;
        end else begin
            memWbQ <= '{regWe: regWe, data: wbData, regIdx: regToWrite};
        end
    end

    assign regWeOut       = memWbQ.regWe;
    assign dataToWriteOut = memWbQ.data;
    assign regToWriteOut  = memWbQ.regIdx;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: each cycle queues a hand-computed MEM/WB bundle and checks it after the edge.
module tb_memory_stage;
    import pipeline_pkg::*;

    localparam int BUNDLE_W = 1 + DATA_W + REG_W;

    logic     clk;
    logic     reset;
    logic     memWe;
    logic     writeRegFromAlu;
    logic     regWe;
    data_t    dataToWrite;
    data_t    result;
    reg_idx_t regToWrite;
    logic     regWeOut;
    data_t    dataToWriteOut;
    reg_idx_t regToWriteOut;

    logic [BUNDLE_W-1:0] exp_q[$];
    int checkCount = 0;
    int passCount  = 0;

    memory_stage dut (
        .clk             (clk),
        .reset           (reset),
        .memWe           (memWe),
        .writeRegFromAlu (writeRegFromAlu),
        .regWe           (regWe),
        .dataToWrite     (dataToWrite),
        .result          (result),
        .regToWrite      (regToWrite),
        .regWeOut        (regWeOut),
        .dataToWriteOut  (dataToWriteOut),
        .regToWriteOut   (regToWriteOut)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected bundle, then check it after the edge.
    task automatic driveCycle(
        input string    tag,
        input logic     rst,
        input logic     we,
        input logic     fromAlu,
        input logic     rwe,
        input data_t    wdata,
        input data_t    res,
        input reg_idx_t rd,
        input logic     expWe,
        input data_t    expData,
        input reg_idx_t expRd
    );
        logic [BUNDLE_W-1:0] exp;
        reset           = rst;
        memWe           = we;
        writeRegFromAlu = fromAlu;
        regWe           = rwe;
        dataToWrite     = wdata;
        result          = res;
        regToWrite      = rd;
        exp_q.push_back({expWe, expData, expRd});
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checkValue({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            exp = exp_q.pop_front();
            checkValue({tag, ".regWeOut"}, 32'(regWeOut), 32'(exp[BUNDLE_W-1]));
            checkValue({tag, ".dataToWriteOut"}, 32'(dataToWriteOut), 32'(exp[REG_W +: DATA_W]));
            checkValue({tag, ".regToWriteOut"}, 32'(regToWriteOut), 32'(exp[REG_W-1:0]));
        end
    endtask

    initial begin
        reset = 1'b1; memWe = 1'b0; writeRegFromAlu = 1'b0; regWe = 1'b0;
        dataToWrite = '0; result = '0; regToWrite = '0;
        @(posedge clk);
        #1;

        //          tag           rst  we   alu  rwe  wdata         result        rd     eWe  eData         eRd
        driveCycle("rst_init",    1,   0,   0,   0,   24'h000000,   24'h000000,   4'd0,  0,   24'h000000,   4'd0);
        driveCycle("seed5",       0,   1,   1,   0,   24'h000000,   24'h000005,   4'd0,  0,   24'h000005,   4'd0);
        driveCycle("rst_hold1",   1,   1,   1,   1,   24'hABCDEF,   24'h000005,   4'd9,  0,   24'h000000,   4'd0);
        driveCycle("rst_hold2",   1,   1,   0,   1,   24'hABCDEF,   24'h000005,   4'd9,  0,   24'h000000,   4'd0);
        driveCycle("load5",       0,   0,   0,   1,   24'h000000,   24'h000005,   4'd2,  1,   24'h000000,   4'd2);
        driveCycle("alu_pass",    0,   0,   1,   1,   24'h000000,   24'h123456,   4'd7,  1,   24'h123456,   4'd7);
        driveCycle("store10",     0,   1,   1,   0,   24'hCAFE01,   24'h000010,   4'd0,  0,   24'h000010,   4'd0);
        driveCycle("load10",      0,   0,   0,   1,   24'h000000,   24'h000010,   4'd3,  1,   24'hCAFE01,   4'd3);
        driveCycle("store20",     0,   1,   1,   0,   24'h000111,   24'h000020,   4'd0,  0,   24'h000020,   4'd0);
        driveCycle("rbw",         0,   1,   0,   1,   24'h000222,   24'h000020,   4'd4,  1,   24'h000111,   4'd4);
        driveCycle("rbw_after",   0,   0,   0,   1,   24'h000000,   24'h000020,   4'd5,  1,   24'h000222,   4'd5);
        driveCycle("wrap_store",  0,   1,   1,   0,   24'h00AAAA,   24'h000105,   4'd0,  0,   24'h000105,   4'd0);
        driveCycle("wrap_load",   0,   0,   0,   1,   24'h000000,   24'h000005,   4'd6,  1,   24'h00AAAA,   4'd6);
        driveCycle("wrap_hi",     0,   0,   0,   1,   24'h000000,   24'hFFFF10,   4'd15, 1,   24'hCAFE01,   4'd15);
        driveCycle("pre_rst",     0,   0,   1,   1,   24'h000000,   24'h0F0F0F,   4'd9,  1,   24'h0F0F0F,   4'd9);
        driveCycle("mid_rst",     1,   1,   1,   1,   24'h999999,   24'h777720,   4'd10, 0,   24'h000000,   4'd0);
        driveCycle("post_rst",    0,   0,   1,   1,   24'h000000,   24'hABCDE0,   4'd12, 1,   24'hABCDE0,   4'd12);
        driveCycle("rst_nowr",    0,   0,   0,   1,   24'h000000,   24'h000020,   4'd1,  1,   24'h000222,   4'd1);

        checkValue("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
